// File: rtl/slv_pkg.sv
// rtl/slv_pkg.sv - internal-ID AXI4 types and error-responder constants
package slv_pkg;

  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiUserWidth = 1;
  localparam int unsigned CntWidth     = 10;

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [AxiDataWidth-1:0] DefaultRespData = 64'hBADC_AB1E_BADC_AB1E;

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} err_wr_state_e;
  typedef enum logic       {R_IDLE, R_SEND}          err_rd_state_e;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [AxiUserWidth-1:0] user;
  } ax_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserWidth-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [AxiUserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [AxiUserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } slv_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } slv_resp_t;

endpackage

// File: rtl/axi_mon_err_slv.sv
// rtl/axi_mon_err_slv.sv - terminating AXI4 error responder (macro AXI_MON_ERR_SLV_DECERR_EN selects DECERR)
module axi_mon_err_slv #(
  parameter type req_t  = slv_pkg::slv_req_t,
  parameter type resp_t = slv_pkg::slv_resp_t,
  parameter logic [slv_pkg::AxiDataWidth-1:0] RespData = slv_pkg::DefaultRespData,
  parameter int unsigned CntWidth = slv_pkg::CntWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  req_t                slv_req_i,
  output resp_t               slv_resp_o,
  output logic                busy_o,
  output logic [CntWidth-1:0] err_cnt_o,
  input  logic                cnt_clr_i
);

`ifdef AXI_MON_ERR_SLV_DECERR_EN
  localparam logic [1:0] ErrResp = slv_pkg::RESP_DECERR;
`else
  localparam logic [1:0] ErrResp = slv_pkg::RESP_SLVERR;
`endif

  slv_pkg::err_wr_state_e             w_state_q;
  slv_pkg::err_rd_state_e             r_state_q;
  logic [slv_pkg::AxiIdWidth-1:0]     aw_id_q, ar_id_q;
  logic [7:0]                         len_q, beat_q;
  logic [CntWidth-1:0]                cnt_q, cnt_d;
  logic                               b_hs, r_last_hs, r_last;
  logic [CntWidth:0]                  cnt_sum;

  // Address, data and burst fields are intentionally ignored
  logic unused_req;
  assign unused_req = ^slv_req_i;

  assign r_last    = (beat_q == len_q);
  assign b_hs      = (w_state_q == slv_pkg::W_RESP) && slv_req_i.b_ready;
  assign r_last_hs = (r_state_q == slv_pkg::R_SEND) && slv_req_i.r_ready && r_last;

  // Write FSM: accept AW, drain W until last, then answer with an error B
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= slv_pkg::W_IDLE;
      aw_id_q   <= '0;
    end else begin
      unique case (w_state_q)
        slv_pkg::W_IDLE: if (en_i && slv_req_i.aw_valid) begin
          aw_id_q   <= slv_req_i.aw.id;
          w_state_q <= slv_pkg::W_DRAIN;
        end
        slv_pkg::W_DRAIN: if (slv_req_i.w_valid && slv_req_i.w.last) w_state_q <= slv_pkg::W_RESP;
        slv_pkg::W_RESP:  if (slv_req_i.b_ready) w_state_q <= slv_pkg::W_IDLE;
        default:          w_state_q <= slv_pkg::W_IDLE;
      endcase
    end
  end

  // Read FSM: accept AR, emit len+1 error beats, one per R handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= slv_pkg::R_IDLE;
      ar_id_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
    end else begin
      unique case (r_state_q)
        slv_pkg::R_IDLE: if (en_i && slv_req_i.ar_valid) begin
          ar_id_q   <= slv_req_i.ar.id;
          len_q     <= slv_req_i.ar.len;
          beat_q    <= '0;
          r_state_q <= slv_pkg::R_SEND;
        end
        slv_pkg::R_SEND: if (slv_req_i.r_ready) begin
          if (r_last) r_state_q <= slv_pkg::R_IDLE;
          else        beat_q    <= beat_q + 8'd1;
        end
        default: r_state_q <= slv_pkg::R_IDLE;
      endcase
    end
  end

  // Saturating error counter; clear wins over same-cycle completions
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + {{(CntWidth-1){1'b0}}, ({1'b0, b_hs} + {1'b0, r_last_hs})};
    cnt_d   = cnt_q;
    if (cnt_clr_i)          cnt_d = '0;
    else if (cnt_sum[CntWidth]) cnt_d = '1;
    else                    cnt_d = cnt_sum[CntWidth-1:0];
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Channel outputs decoded purely from registered state (plus en_i for AW/AR)
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = en_i && (w_state_q == slv_pkg::W_IDLE);
    slv_resp_o.w_ready  = (w_state_q == slv_pkg::W_DRAIN);
    slv_resp_o.b_valid  = (w_state_q == slv_pkg::W_RESP);
    if (w_state_q == slv_pkg::W_RESP) begin
      slv_resp_o.b.id   = aw_id_q;
      slv_resp_o.b.resp = ErrResp;
    end
    slv_resp_o.ar_ready = en_i && (r_state_q == slv_pkg::R_IDLE);
    slv_resp_o.r_valid  = (r_state_q == slv_pkg::R_SEND);
    if (r_state_q == slv_pkg::R_SEND) begin
      slv_resp_o.r.id   = ar_id_q;
      slv_resp_o.r.data = RespData;
      slv_resp_o.r.resp = ErrResp;
      slv_resp_o.r.last = r_last;
    end
  end

  assign busy_o    = (w_state_q != slv_pkg::W_IDLE) || (r_state_q != slv_pkg::R_IDLE);
  assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_axi_mon_err_slv.sv
// tb/tb_axi_mon_err_slv.sv - scoreboard bench for axi_mon_err_slv
module tb_axi_mon_err_slv;
  import slv_pkg::*;

`ifdef AXI_MON_ERR_SLV_DECERR_EN
  localparam logic [1:0] ExpResp = 2'b11;
`else
  localparam logic [1:0] ExpResp = 2'b10;
`endif
  localparam logic [63:0] ExpData = 64'hBADC_AB1E_BADC_AB1E;

  typedef struct packed {
    logic [3:0] id;
    logic       last;
  } exp_r_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       busy;
  logic [9:0] err_cnt;
  slv_req_t   req;
  slv_resp_t  resp;

  int n_chk = 0;
  int n_err = 0;
  int b_hs_cnt = 0;
  int r_hs_cnt = 0;

  logic [3:0] exp_b_q[$];
  exp_r_t     exp_r_q[$];

  always #5 clk = ~clk;

  axi_mon_err_slv dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .slv_req_i  (req),
    .slv_resp_o (resp),
    .busy_o     (busy),
    .err_cnt_o  (err_cnt),
    .cnt_clr_i  (cnt_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every B/R handshake, checks hold while stalled
  logic       b_stall = 1'b0;
  logic       r_stall = 1'b0;
  b_chan_t    b_held;
  r_chan_t    r_held;
  logic [3:0] eb;
  exp_r_t     er;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_stall = 1'b0;
      r_stall = 1'b0;
    end else begin
      if (b_stall) chk("b_hold", {resp.b_valid, resp.b}, {1'b1, b_held});
      if (r_stall) chk("r_hold", {resp.r_valid, resp.r}, {1'b1, r_held});
      if (resp.b_valid && req.b_ready) begin
        b_hs_cnt++;
        if (exp_b_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL b_unexpected: got id %0h expected no B", resp.b.id);
        end else begin
          eb = exp_b_q.pop_front();
          chk("b_id", resp.b.id, eb);
          chk("b_resp", resp.b.resp, ExpResp);
          chk("b_user", resp.b.user, 0);
        end
      end
      if (resp.r_valid && req.r_ready) begin
        r_hs_cnt++;
        if (exp_r_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL r_unexpected: got id %0h expected no R", resp.r.id);
        end else begin
          er = exp_r_q.pop_front();
          chk("r_id", resp.r.id, er.id);
          chk("r_data", resp.r.data, ExpData);
          chk("r_resp", resp.r.resp, ExpResp);
          chk("r_last", resp.r.last, er.last);
          chk("r_user", resp.r.user, 0);
        end
      end
      b_stall = resp.b_valid && !req.b_ready;
      b_held  = resp.b;
      r_stall = resp.r_valid && !req.r_ready;
      r_held  = resp.r;
    end
  end

  // AW and AR in one cycle; B and last R handshake coincide
  task automatic both(input logic [3:0] wid, input logic [3:0] rid, input logic [9:0] pre, input logic [9:0] post);
    req.aw.id = wid; req.aw_valid = 1'b1;
    req.ar.id = rid; req.ar.len = 8'd0; req.ar_valid = 1'b1;
    req.b_ready = 1'b0; req.r_ready = 1'b0;
    step();
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    req.w_valid = 1'b1; req.w.last = 1'b1;
    sample();
    chk("both_w_ready", resp.w_ready, 1);
    step();
    req.w_valid = 1'b0;
    sample();
    chk("both_b_valid", resp.b_valid, 1);
    chk("both_r_valid", resp.r_valid, 1);
    chk("both_cnt_pre", err_cnt, pre);
    exp_b_q.push_back(wid);
    exp_r_q.push_back('{id: rid, last: 1'b1});
    step();
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    step();
    req.b_ready = 1'b0; req.r_ready = 1'b0;
    sample();
    chk("both_cnt_post", err_cnt, post);
    chk("both_busy", busy, 0);
  endtask

  task automatic wait_r(input int target, input int limit, input string name);
    int cyc;
    cyc = 0;
    while (r_hs_cnt < target && cyc < limit) begin
      step();
      cyc++;
    end
    if (r_hs_cnt < target) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: got %0d beats expected %0d", name, r_hs_cnt, target);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int start, cyc;
    req = '0;
    en  = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    sample();
    chk("rst_busy", busy, 0);
    chk("rst_b_valid", resp.b_valid, 0);
    chk("rst_r_valid", resp.r_valid, 0);
    chk("rst_w_ready", resp.w_ready, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_aw_ready", resp.aw_ready, 1);
    chk("rst_ar_ready", resp.ar_ready, 1);

    // Write: AW id=1, four W beats
    step();
    req.aw.id = 4'd1; req.aw_valid = 1'b1; req.b_ready = 1'b1;
    exp_b_q.push_back(4'd1);
    step();
    req.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req.w_valid = 1'b1; req.w.last = (i == 3);
      req.w.data = 64'h1111 * (i + 1);
      sample();
      chk("wr_w_ready", resp.w_ready, 1);
      chk("wr_aw_ready_busy", resp.aw_ready, 0);
      chk("wr_b_early", resp.b_valid, 0);
      step();
    end
    req.w_valid = 1'b0; req.w.last = 1'b0;
    sample();
    chk("wr_b_valid", resp.b_valid, 1);
    step();
    sample();
    chk("wr_b_done", resp.b_valid, 0);
    chk("wr_cnt", err_cnt, 1);
    chk("wr_aw_ready_again", resp.aw_ready, 1);
    chk("wr_b_count", b_hs_cnt, 1);
    req.b_ready = 1'b0;

    // Read: AR id=3 len=7 with r_ready toggling
    for (int i = 0; i < 8; i++) exp_r_q.push_back('{id: 4'd3, last: (i == 7)});
    step();
    req.ar.id = 4'd3; req.ar.len = 8'd7; req.ar_valid = 1'b1;
    step();
    req.ar_valid = 1'b0;
    sample();
    chk("rd_r_valid_first", resp.r_valid, 1);
    chk("rd_ar_ready_busy", resp.ar_ready, 0);
    start = r_hs_cnt;
    cyc = 0;
    while (r_hs_cnt - start < 8 && cyc < 100) begin
      step();
      req.r_ready = (cyc % 2 == 0);
      cyc++;
    end
    req.r_ready = 1'b0;
    chk("rd_beats", r_hs_cnt - start, 8);
    sample();
    chk("rd_r_valid_done", resp.r_valid, 0);
    chk("rd_ar_ready_again", resp.ar_ready, 1);
    chk("rd_cnt", err_cnt, 2);

    // Concurrent write and read, +2 in one cycle
    step();
    both(4'd5, 4'd6, 10'd2, 10'd4);

    // en_i low: nothing accepted
    step();
    en = 1'b0; req.aw_valid = 1'b1; req.ar_valid = 1'b1; req.ar.len = 8'd0;
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("dis_aw_ready", resp.aw_ready, 0);
      chk("dis_ar_ready", resp.ar_ready, 0);
      step();
    end
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    sample();
    chk("dis_busy", busy, 0);

    // 256-beat read with en toggling mid-burst
    for (int i = 0; i < 256; i++) exp_r_q.push_back('{id: 4'd2, last: (i == 255)});
    step();
    en = 1'b1; req.ar.id = 4'd2; req.ar.len = 8'd255; req.ar_valid = 1'b1;
    step();
    req.ar_valid = 1'b0; req.r_ready = 1'b1;
    start = r_hs_cnt;
    cyc = 0;
    en = 1'b0;
    while (r_hs_cnt - start < 256 && cyc < 400) begin
      step();
      cyc++;
      if (cyc == 50) en = 1'b1;
      if (cyc == 60) chk("long_ar_ready_busy", resp.ar_ready, 0);
      if (cyc == 100) en = 1'b0;
    end
    req.r_ready = 1'b0;
    chk("long_beats", r_hs_cnt - start, 256);
    sample();
    chk("long_r_valid_done", resp.r_valid, 0);
    chk("long_busy", busy, 0);
    chk("long_ar_ready_en0", resp.ar_ready, 0);
    chk("long_cnt", err_cnt, 5);
    step();
    en = 1'b1;

    // Fill counter up to 1022 with single-beat reads
    for (int k = 5; k < 1022; k++) begin
      exp_r_q.push_back('{id: 4'd7, last: 1'b1});
      req.ar.id = 4'd7; req.ar.len = 8'd0; req.ar_valid = 1'b1;
      step();
      req.ar_valid = 1'b0; req.r_ready = 1'b1;
      step();
      req.r_ready = 1'b0;
    end
    sample();
    chk("fill_cnt", err_cnt, 1022);

    // Saturation on a double increment
    step();
    both(4'd8, 4'd9, 10'd1022, 10'd1023);

    // Clear beats a same-cycle increment
    step();
    exp_r_q.push_back('{id: 4'd10, last: 1'b1});
    req.ar.id = 4'd10; req.ar.len = 8'd0; req.ar_valid = 1'b1;
    step();
    req.ar_valid = 1'b0; req.r_ready = 1'b1; cnt_clr = 1'b1;
    step();
    req.r_ready = 1'b0; cnt_clr = 1'b0;
    sample();
    chk("clr_cnt", err_cnt, 0);

    // One write so the counter is nonzero before reset
    step();
    exp_b_q.push_back(4'd11);
    req.aw.id = 4'd11; req.aw_valid = 1'b1;
    step();
    req.aw_valid = 1'b0; req.w_valid = 1'b1; req.w.last = 1'b1;
    step();
    req.w_valid = 1'b0; req.b_ready = 1'b1;
    step();
    req.b_ready = 1'b0;
    sample();
    chk("pre_rst_cnt", err_cnt, 1);

    // Reset mid-burst at beat 3 of 8
    for (int i = 0; i < 3; i++) exp_r_q.push_back('{id: 4'd4, last: 1'b0});
    step();
    req.ar.id = 4'd4; req.ar.len = 8'd7; req.ar_valid = 1'b1;
    step();
    req.ar_valid = 1'b0; req.r_ready = 1'b1;
    start = r_hs_cnt;
    step(); step(); step();
    chk("mid_beats", r_hs_cnt - start, 3);
    req.r_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_r_valid", resp.r_valid, 0);
    chk("arst_b_valid", resp.b_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cnt", err_cnt, 0);
    step(); step();
    rst_n = 1'b1; req.r_ready = 1'b1; req.b_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample();
      chk("post_rst_r_valid", resp.r_valid, 0);
      step();
    end
    req.r_ready = 1'b0; req.b_ready = 1'b0;

    chk("left_b", exp_b_q.size(), 0);
    chk("left_r", exp_r_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_mon_err_slv.md
# axi_mon_err_slv

Terminating AXI4 responder on the monitor's internal-ID (slv-typed) side. When the monitor isolates a hung downstream, this block takes its place. It accepts every write and read request and completes it with an error response, so the upstream master is never left with dangling transactions. It counts the error responses it has issued, for the monitor's register file.

## Interface
Parameters:
- `req_t`, default `slv_pkg::slv_req_t`: AXI request type, internal ID width.
- `resp_t`, default `slv_pkg::slv_resp_t`: AXI response type.
- `RespData`, default `64'hBADC_AB1E_BADC_AB1E`: value driven on every R beat; width `slv_pkg::AxiDataWidth`.
- `CntWidth`, default `slv_pkg::CntWidth` (10): width of the error counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `en_i`, in, 1: accept new AW/AR when high. Transactions already in flight always complete.
- `slv_req_i`, in, `req_t`: AW/W/AR channels plus `b_ready`/`r_ready`.
- `slv_resp_o`, out, `resp_t`: ready signals, B and R channels.
- `busy_o`, out, 1: high when either FSM is not idle.
- `err_cnt_o`, out, `CntWidth`: saturating count of completed error responses.
- `cnt_clr_i`, in, 1: synchronous clear of `err_cnt_o`.

## Operation
- Write FSM, states `W_IDLE`, `W_DRAIN`, `W_RESP`:
  - `W_IDLE`: `aw_ready = en_i`; `w_ready = 0`. On an AW handshake, capture `aw.id` and go to `W_DRAIN`.
  - `W_DRAIN`: `w_ready = 1`. Data is discarded. On a W handshake with `w.last`, go to `W_RESP`.
  - `W_RESP`: `b_valid = 1`, `b.id` = captured ID, `b.resp` = ERR, `b.user = 0`. On `b_ready`, go to `W_IDLE`.
  - W beats presented before AW are back-pressured, which is legal AXI. The burst length is not checked; `w.last` alone ends the drain.
- Read FSM, states `R_IDLE`, `R_SEND`:
  - `R_IDLE`: `ar_ready = en_i`. On an AR handshake, capture `ar.id` and `ar.len` (8 b), clear the beat counter and go to `R_SEND`.
  - `R_SEND`: `r_valid = 1`, `r.data = RespData`, `r.resp = ERR`, `r.id` = captured ID, `r.user = 0`, `r.last = (beat_cnt == len)`.
    - The beat counter increments on each R handshake.
    - The handshake with `r.last` returns the FSM to `R_IDLE`.
  - `len = 255` produces 256 beats; the 8-bit counter never wraps before `last`.
- Write and read FSMs are fully independent and may be active in the same cycle.
- One outstanding transaction per direction. `aw_ready`/`ar_ready` are low while the respective FSM is busy.
- Error counter: increments by 1 on each B handshake and by 1 on each R handshake with `last`.
  - If both occur in the same cycle, it increments by 2.
  - It saturates at all-ones and never wraps.
  - `cnt_clr_i` has priority over any increment in the same cycle.
- ERR = `2'b10` (SLVERR), unless the macro below is defined.

## Timing
- Reset values: both FSMs idle, `b_valid = r_valid = 0`, captured ID/len/beat counter = 0, `err_cnt_o = 0`, `busy_o = 0`.
- `aw_ready`/`ar_ready` = `en_i` in the first cycle after reset release.
- All ready/valid outputs are decoded from registered state. There is no combinational path from any `*_valid`/`*_ready` input to any output.
- AW handshake in cycle n → `w_ready` high in n+1.
- W `last` handshake in cycle n → `b_valid` in n+1.
- AR handshake in cycle n → first `r_valid` in n+1.
- Back-to-back R beats at one per cycle while `r_ready` stays high.
- The earliest next AW/AR acceptance is the cycle after the B handshake or the R `last` handshake.
- `b_valid`/`r_valid` and their payloads are held stable until the handshake.
- `en_i` falling mid-transaction has no effect on that transaction.
- Asynchronous reset mid-burst aborts immediately to the reset values. No residual beats are emitted.

## Configuration
- `AXI_MON_ERR_SLV_DECERR_EN`
  - Defined: every B and R response carries DECERR (`2'b11`).
  - Undefined (default): responses carry SLVERR (`2'b10`).
  - No other behaviour changes.

## Structure
- `slv_pkg` additions:
  - Constants `RESP_SLVERR`/`RESP_DECERR`.
  - Enums `err_wr_state_e` (`W_IDLE`, `W_DRAIN`, `W_RESP`) and `err_rd_state_e` (`R_IDLE`, `R_SEND`).
  - Default `RespData`.
- Single flat module. The two FSMs are small enough that no sub-module is warranted. The saturating counter is inline.

## Test plan
- AW id=1 then 4 W beats (`last` on the 4th) → `w_ready` high from the cycle after AW; exactly one B with id=1, resp=`2'b10`, in the cycle after the 4th beat; `err_cnt_o` = 1.
- AR id=3, len=7, `r_ready` toggling 1/0 → exactly 8 R beats, data `RespData`, resp=`2'b10`, `last` only on the 8th; payload stable while stalled; then `ar_ready` = 1.
- AW and AR issued in the same cycle; B handshake and R `last` handshake coincide → both served concurrently; `err_cnt_o` +2 in that cycle.
- `en_i` = 0 with AW/AR valid → no acceptance for 10 cycles. Raise `en_i` during an in-flight 256-beat read, then drop it → the read completes with 256 beats and no wrap.
- Preload counter to 1022, then two coincident completions → 1023 (saturated). `cnt_clr_i` together with an increment → 0.
- Reset asserted mid-burst (beat 3 of 8) → `r_valid`/`b_valid` drop asynchronously, `busy_o` = 0, and no further beats after release. Rerun with `AXI_MON_ERR_SLV_DECERR_EN` defined → resp=`2'b11`.
